// File: rtl/network_sequencer.sv
// Sequences one inference through a two-layer network: drives the layer 0 and
// layer 1 enables in turn, captures each layer's results, then scans the class
// scores one per cycle to find the winning class and reports it as a pulse.
module network_sequencer #(
  parameter int numHidden     = 16,
  parameter int numClasses    = 10,
  parameter int dataWidth     = 16,
  parameter int timeoutCycles = 2048
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            inValid,
  output logic                            inReady,
  input  logic                            abort,
  output logic                            l0Valid,
  input  logic                            l0OutValid,
  input  logic [dataWidth*numHidden-1:0]  l0Out,
  output logic [dataWidth*numHidden-1:0]  l1In,
  output logic                            l1Valid,
  input  logic                            l1OutValid,
  input  logic [dataWidth*numClasses-1:0] l1Out,
  output logic [$clog2(numClasses)-1:0]   result,
  output logic [dataWidth-1:0]            resultScore,
  output logic                            resultValid,
  output logic                            busy,
  output logic                            timeoutErr
);

  localparam int idxW = $clog2(numClasses);
  localparam int cntW = $clog2(timeoutCycles);
  localparam logic [idxW-1:0] lastIdx   = idxW'(numClasses - 1);
  localparam logic [cntW-1:0] waitLimit = cntW'(timeoutCycles - 1);

  typedef enum logic [2:0] {
    IDLE,
    L0_RUN,
    L1_RUN,
    ARGMAX,
    DONE
  } state_t;

  state_t                       state_q, state_d;
  logic [cntW-1:0]              waitCnt_q, waitCnt_d;
  logic [idxW-1:0]              idx_q, idx_d;
  logic signed [dataWidth-1:0]  best_q, best_d;
  logic [idxW-1:0]              bestIdx_q, bestIdx_d;
  logic                         timeoutErr_q, timeoutErr_d;
  logic [dataWidth*numHidden-1:0] l1In_q;
  logic signed [dataWidth-1:0]  scoreBuf_q [numClasses];
  logic [idxW-1:0]              result_q;
  logic [dataWidth-1:0]         resultScore_q;
  logic                         resultValid_q;

  logic                         captureL0;
  logic                         captureL1;
  logic                         fireDone;
  logic signed [dataWidth-1:0]  curScore;

  assign curScore = scoreBuf_q[idx_q];

  // Next-state logic: abort always wins over a layer's output valid, and a
  // layer that never answers within the wait budget ends the inference.
  always_comb begin
    state_d      = state_q;
    waitCnt_d    = waitCnt_q;
    idx_d        = idx_q;
    best_d       = best_q;
    bestIdx_d    = bestIdx_q;
    timeoutErr_d = timeoutErr_q;
    captureL0    = 1'b0;
    captureL1    = 1'b0;
    fireDone     = 1'b0;
    case (state_q)
      IDLE: begin
        if (inValid) begin
          state_d      = L0_RUN;
          waitCnt_d    = '0;
          timeoutErr_d = 1'b0;
        end
      end
      L0_RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (l0OutValid) begin
          captureL0 = 1'b1;
          state_d   = L1_RUN;
          waitCnt_d = '0;
        end else if (waitCnt_q == waitLimit) begin
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      L1_RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (l1OutValid) begin
          captureL1 = 1'b1;
          state_d   = ARGMAX;
          idx_d     = '0;
        end else if (waitCnt_q == waitLimit) begin
          timeoutErr_d = 1'b1;
          state_d      = IDLE;
        end else begin
          waitCnt_d = waitCnt_q + 1'b1;
        end
      end
      ARGMAX: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          // Index 0 seeds the running best; later indices replace it only
          // when strictly greater, so ties resolve to the lowest index.
          if ((idx_q == '0) || (curScore > best_q)) begin
            best_d    = curScore;
            bestIdx_d = idx_q;
          end
          if (idx_q == lastIdx) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d  = IDLE;
        fireDone = !abort;
      end
      default: state_d = IDLE;
    endcase
  end

  // Control state register: FSM state, wait counter, scan index and running best.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      waitCnt_q    <= '0;
      idx_q        <= '0;
      best_q       <= '0;
      bestIdx_q    <= '0;
      timeoutErr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      waitCnt_q    <= waitCnt_d;
      idx_q        <= idx_d;
      best_q       <= best_d;
      bestIdx_q    <= bestIdx_d;
      timeoutErr_q <= timeoutErr_d;
    end
  end

  // Layer 0 results are held for layer 1 and change only on the capture edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l1In_q <= '0;
    end else if (captureL0) begin
      l1In_q <= l0Out;
    end
  end

  // Class scores are buffered so layer 1 may change its outputs during the scan.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < numClasses; i++) begin
        scoreBuf_q[i] <= '0;
      end
    end else if (captureL1) begin
      for (int i = 0; i < numClasses; i++) begin
        scoreBuf_q[i] <= l1Out[i*dataWidth +: dataWidth];
      end
    end
  end

  // Result registers load once per completed inference and hold until the next.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      result_q      <= '0;
      resultScore_q <= '0;
      resultValid_q <= 1'b0;
    end else begin
      resultValid_q <= fireDone;
      if (fireDone) begin
        result_q      <= bestIdx_q;
        resultScore_q <= best_q;
      end
    end
  end

  assign inReady     = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign l0Valid     = (state_q == L0_RUN);
  assign l1Valid     = (state_q == L1_RUN);
  assign l1In        = l1In_q;
  assign result      = result_q;
  assign resultScore = resultScore_q;
  assign resultValid = resultValid_q;
  assign timeoutErr  = timeoutErr_q;

endmodule

// File: tb/tb_network_sequencer.sv
// Directed and randomized-latency bench for network_sequencer.
module tb_network_sequencer;

  localparam int NH = 16;
  localparam int NC = 10;
  localparam int DW = 16;
  localparam int TO = 2048;

  logic              clk;
  logic              reset;
  logic              inValid;
  logic              inReady;
  logic              abort;
  logic              l0Valid;
  logic              l0OutValid;
  logic [DW*NH-1:0]  l0Out;
  logic [DW*NH-1:0]  l1In;
  logic              l1Valid;
  logic              l1OutValid;
  logic [DW*NC-1:0]  l1Out;
  logic [3:0]        result;
  logic [DW-1:0]     resultScore;
  logic              resultValid;
  logic              busy;
  logic              timeoutErr;

  int checks;
  int errors;
  bit overlapSeen;

  network_sequencer #(
    .numHidden(NH), .numClasses(NC), .dataWidth(DW), .timeoutCycles(TO)
  ) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady), .abort(abort),
    .l0Valid(l0Valid), .l0OutValid(l0OutValid), .l0Out(l0Out), .l1In(l1In),
    .l1Valid(l1Valid), .l1OutValid(l1OutValid), .l1Out(l1Out), .result(result),
    .resultScore(resultScore), .resultValid(resultValid), .busy(busy),
    .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (l0Valid && l1Valid) overlapSeen = 1'b1;
  endtask

  function automatic logic [DW*NH-1:0] hiddenPattern(input int seed);
    logic [DW*NH-1:0] v;
    for (int i = 0; i < NH; i++) v[i*DW +: DW] = 16'(seed + i * 257);
    return v;
  endfunction

  function automatic logic [DW*NC-1:0] packScores(input logic signed [DW-1:0] s [NC]);
    logic [DW*NC-1:0] v;
    for (int i = 0; i < NC; i++) v[i*DW +: DW] = s[i];
    return v;
  endfunction

  // Drives one full inference; latency is counted in edges after the accept edge.
  task automatic runInference(input int w0, input int w1, input logic [DW*NC-1:0] scores,
                              input logic [DW*NH-1:0] hid, output int latency,
                              output int pulses);
    int edges;
    latency = -1;
    pulses  = 0;
    edges   = 0;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (w0) begin tick(); edges++; end
    l0Out = hid;
    l0OutValid = 1'b1;
    tick(); edges++;
    l0OutValid = 1'b0;
    l0Out = '0;
    repeat (w1) begin tick(); edges++; end
    l1Out = scores;
    l1OutValid = 1'b1;
    tick(); edges++;
    l1OutValid = 1'b0;
    l1Out = '1;
    for (int i = 0; i < NC + 12; i++) begin
      tick(); edges++;
      if (resultValid) begin
        pulses++;
        if (latency < 0) latency = edges;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({inReady, busy} !== 2'b10) begin
      errors++; $display("[TB] FAIL reset_ready_busy: got %b expected 10", {inReady, busy});
    end
    checks++;
    if ({l0Valid, l1Valid, resultValid, timeoutErr} !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_flags: got %b expected 0000",
                         {l0Valid, l1Valid, resultValid, timeoutErr});
    end
    checks++;
    if (result !== 4'd0 || resultScore !== 16'd0 || l1In !== '0) begin
      errors++; $display("[TB] FAIL reset_data: got result %0d score %0d expected 0 0", result, resultScore);
    end
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    checks++;
    if ({l0Valid, busy, inReady} !== 3'b110) begin
      errors++; $display("[TB] FAIL first_edge_accept: got %b expected 110", {l0Valid, busy, inReady});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({inReady, l0Valid, resultValid} !== 3'b100) begin
      errors++; $display("[TB] FAIL abort_l0: got %b expected 100", {inReady, l0Valid, resultValid});
    end
  endtask

  task automatic test_nominal();
    logic signed [DW-1:0] s [NC];
    int lat, pul;
    s = '{16'sd1, 16'sd5, -16'sd3, 16'sd9, 16'sd2, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd9};
    runInference(785, 17, packScores(s), hiddenPattern(11), lat, pul);
    checks++;
    if (lat !== 815) begin
      errors++; $display("[TB] FAIL nominal_latency: got %0d expected 815", lat);
    end
    checks++;
    if (pul !== 1) begin
      errors++; $display("[TB] FAIL nominal_pulses: got %0d expected 1", pul);
    end
    checks++;
    if (result !== 4'd3 || resultScore !== 16'd9) begin
      errors++; $display("[TB] FAIL nominal_result: got %0d/%0d expected 3/9", result, resultScore);
    end
    checks++;
    if (l1In !== hiddenPattern(11)) begin
      errors++; $display("[TB] FAIL nominal_l1In: got %h expected %h", l1In, hiddenPattern(11));
    end
    repeat (5) tick();
    checks++;
    if (result !== 4'd3 || resultScore !== 16'd9 || inReady !== 1'b1) begin
      errors++; $display("[TB] FAIL result_hold: got %0d/%0d expected 3/9", result, resultScore);
    end
  endtask

  task automatic test_ties();
    logic signed [DW-1:0] s [NC];
    int lat, pul;
    for (int i = 0; i < NC; i++) s[i] = -16'sd4;
    runInference(2, 3, packScores(s), hiddenPattern(5), lat, pul);
    checks++;
    if (result !== 4'd0 || resultScore !== 16'hFFFC || pul !== 1) begin
      errors++; $display("[TB] FAIL ties_negative: got %0d/%h pulses %0d expected 0/fffc pulses 1",
                         result, resultScore, pul);
    end
    for (int i = 0; i < NC; i++) s[i] = 16'sh8000;
    s[NC-1] = 16'sh8001;
    runInference(0, 0, packScores(s), hiddenPattern(6), lat, pul);
    checks++;
    if (result !== 4'd9 || resultScore !== 16'h8001) begin
      errors++; $display("[TB] FAIL most_negative: got %0d/%h expected 9/8001", result, resultScore);
    end
    checks++;
    if (lat !== 13) begin
      errors++; $display("[TB] FAIL zero_wait_latency: got %0d expected 13", lat);
    end
  endtask

  task automatic test_timeout();
    int pul;
    pul = 0;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (resultValid) pul++;
    end
    checks++;
    if ({timeoutErr, l0Valid} !== 2'b01) begin
      errors++; $display("[TB] FAIL timeout_early: got %b expected 01", {timeoutErr, l0Valid});
    end
    tick();
    if (resultValid) pul++;
    checks++;
    if ({timeoutErr, l0Valid, inReady} !== 3'b101) begin
      errors++; $display("[TB] FAIL timeout_flag: got %b expected 101", {timeoutErr, l0Valid, inReady});
    end
    repeat (5) begin tick(); if (resultValid) pul++; end
    checks++;
    if (pul !== 0 || timeoutErr !== 1'b1) begin
      errors++; $display("[TB] FAIL timeout_sticky: got pulses %0d flag %b expected 0 1", pul, timeoutErr);
    end
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    checks++;
    if ({timeoutErr, l0Valid} !== 2'b01) begin
      errors++; $display("[TB] FAIL timeout_clear: got %b expected 01", {timeoutErr, l0Valid});
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_abort();
    int pul;
    logic [DW*NC-1:0] sc;
    pul = 0;
    sc = '0;
    sc[4*DW +: DW] = 16'd77;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (3) tick();
    l0Out = hiddenPattern(99);
    l0OutValid = 1'b1;
    tick();
    l0OutValid = 1'b0;
    l0Out = '0;
    repeat (2) tick();
    abort = 1'b1;
    l1OutValid = 1'b1;
    l1Out = sc;
    tick();
    abort = 1'b0;
    l1OutValid = 1'b0;
    checks++;
    if ({inReady, l1Valid, busy} !== 3'b100) begin
      errors++; $display("[TB] FAIL abort_l1: got %b expected 100", {inReady, l1Valid, busy});
    end
    checks++;
    if (l1In !== hiddenPattern(99)) begin
      errors++; $display("[TB] FAIL abort_l1In: got %h expected %h", l1In, hiddenPattern(99));
    end
    repeat (20) begin tick(); if (resultValid) pul++; end
    checks++;
    if (pul !== 0 || result !== 4'd9 || timeoutErr !== 1'b0) begin
      errors++; $display("[TB] FAIL abort_no_result: got pulses %0d result %0d expected 0 9", pul, result);
    end
  endtask

  task automatic test_reset_mid();
    logic signed [DW-1:0] s [NC];
    int lat, pul;
    pul = 0;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    l0Out = hiddenPattern(3);
    l0OutValid = 1'b1;
    tick();
    l0OutValid = 1'b0;
    l1Out = '0;
    l1OutValid = 1'b1;
    tick();
    l1OutValid = 1'b0;
    repeat (3) tick();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({inReady, busy, l0Valid, l1Valid, resultValid, timeoutErr} !== 6'b100000) begin
      errors++; $display("[TB] FAIL reset_mid_flags: got %b expected 100000",
                         {inReady, busy, l0Valid, l1Valid, resultValid, timeoutErr});
    end
    checks++;
    if (result !== 4'd0 || resultScore !== 16'd0 || l1In !== '0) begin
      errors++; $display("[TB] FAIL reset_mid_data: got %0d/%h expected 0/0", result, resultScore);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (20) begin tick(); if (resultValid) pul++; end
    for (int i = 0; i < NC; i++) s[i] = 16'(i * 10 - 30);
    s[6] = 16'sd200;
    runInference(4, 1, packScores(s), hiddenPattern(8), lat, pul);
    checks++;
    if (result !== 4'd6 || resultScore !== 16'd200 || lat !== 18 || pul !== 1) begin
      errors++; $display("[TB] FAIL reset_then_run: got %0d/%0d lat %0d expected 6/200 lat 18",
                         result, resultScore, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [DW-1:0] s [NC];
    logic signed [DW-1:0] bs;
    int bi, w0, w1, lat, pul, totalPulses, badResult, badLatency;
    totalPulses = 0;
    badResult = 0;
    badLatency = 0;
    overlapSeen = 1'b0;
    for (int n = 0; n < 100; n++) begin
      w0 = $urandom_range(0, 20);
      w1 = $urandom_range(0, 20);
      for (int i = 0; i < NC; i++) begin
        if (n % 2 == 0) s[i] = 16'($urandom_range(0, 7)) - 16'sd4;
        else s[i] = 16'($urandom_range(0, 65535));
      end
      bi = 0;
      bs = s[0];
      for (int i = 1; i < NC; i++) if (s[i] > bs) begin bs = s[i]; bi = i; end
      runInference(w0, w1, packScores(s), hiddenPattern(n), lat, pul);
      totalPulses += pul;
      if (result !== 4'(bi) || resultScore !== bs) badResult++;
      if (lat !== w0 + w1 + NC + 3) badLatency++;
    end
    checks++;
    if (overlapSeen !== 1'b0) begin
      errors++; $display("[TB] FAIL exclusivity: got overlap %b expected 0", overlapSeen);
    end
    checks++;
    if (totalPulses !== 100) begin
      errors++; $display("[TB] FAIL random_pulses: got %0d expected 100", totalPulses);
    end
    checks++;
    if (badResult !== 0) begin
      errors++; $display("[TB] FAIL random_argmax: got %0d wrong results expected 0", badResult);
    end
    checks++;
    if (badLatency !== 0) begin
      errors++; $display("[TB] FAIL random_latency: got %0d wrong latencies expected 0", badLatency);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    overlapSeen = 1'b0;
    reset = 1'b0;
    inValid = 1'b0;
    abort = 1'b0;
    l0OutValid = 1'b0;
    l1OutValid = 1'b0;
    l0Out = '0;
    l1Out = '0;
    test_reset();
    test_nominal();
    test_ties();
    test_timeout();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/network_sequencer.md
NETWORK_SEQUENCER -- requirements
Module: network_sequencer

Interface
REQ-001 SHALL have parameter numHidden, default 16, hidden-layer neuron count (layer 0 outputs).
REQ-002 SHALL have parameter numClasses, default 10, output-layer neuron count (layer 1 outputs).
REQ-003 SHALL have parameter dataWidth, default 16, signed fixed-point width per value.
REQ-004 SHALL have parameter timeoutCycles, default 2048, maximum wait for any layer's output valid.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port inValid  input  1  input vector present at layer 0.
REQ-008 SHALL have port inReady  output  1  sequencer can accept a new inference.
REQ-009 SHALL have port abort  input  1  synchronous cancel of the current inference.
REQ-010 SHALL have port l0Valid  output  1  layer 0 enable, held high while layer 0 runs.
REQ-011 SHALL have port l0OutValid  input  1  layer 0 results valid.
REQ-012 SHALL have port l0Out  input  dataWidth*numHidden  layer 0 results.
REQ-013 SHALL have port l1In  output  dataWidth*numHidden  registered layer 0 results driving layer 1.
REQ-014 SHALL have port l1Valid  output  1  layer 1 enable, held high while layer 1 runs.
REQ-015 SHALL have port l1OutValid  input  1  layer 1 results valid.
REQ-016 SHALL have port l1Out  input  dataWidth*numClasses  layer 1 results.
REQ-017 SHALL have port result  output  $clog2(numClasses)  winning class index.
REQ-018 SHALL have port resultScore  output  dataWidth  winning class score.
REQ-019 SHALL have port resultValid  output  1  one-cycle pulse; result and resultScore valid.
REQ-020 SHALL have port busy  output  1  high in every state except IDLE.
REQ-021 SHALL have port timeoutErr  output  1  sticky timeout flag.

Function
REQ-022 SHALL implement states IDLE, L0_RUN, L1_RUN, ARGMAX, DONE.
REQ-023 IDLE: inReady=1; when inValid=1, clear timeoutErr and go to L0_RUN.
REQ-024 L0_RUN: l0Valid=1; when l0OutValid=1, register l0Out into l1In and go to L1_RUN.
REQ-025 L1_RUN: l1Valid=1; when l1OutValid=1, register l1Out into an internal score buffer and go to ARGMAX.
REQ-026 ARGMAX: compare one buffered score per cycle as signed values, indices 0..numClasses-1, over exactly numClasses cycles.
REQ-027 ARGMAX: replace the running best only on strictly greater; ties keep the lowest index.
REQ-028 ARGMAX: after index numClasses-1, go to DONE.
REQ-029 DONE: load result and resultScore, pulse resultValid for 1 cycle, then return to IDLE.
REQ-030 result and resultScore SHALL hold their values until the next DONE.
REQ-031 Latency from accept edge to resultValid SHALL be (L0 wait)+(L1 wait)+numClasses+3 cycles.
REQ-032 A wait counter SHALL clear on entry to L0_RUN and on entry to L1_RUN, and increment each cycle in those states.
REQ-033 When the wait counter reaches timeoutCycles-1 without the output valid: set timeoutErr, drop l0Valid/l1Valid, go to IDLE, and issue no resultValid.
REQ-034 abort=1 in any non-IDLE state: go to IDLE next cycle, with no resultValid and timeoutErr unchanged.
REQ-035 abort=1 together with an output valid in the same cycle: abort wins.
REQ-036 In IDLE, abort has no effect; inValid is ignored in every state except IDLE.
REQ-037 l1In SHALL change only on the L0_RUN capture edge.
REQ-038 l0Valid and l1Valid SHALL never be high in the same cycle.

Reset
REQ-039 reset=0 SHALL asynchronously force: state IDLE, inReady=1, l0Valid=0, l1Valid=0, resultValid=0, busy=0, timeoutErr=0, result=0, resultScore=0, l1In=0, wait counter=0, score buffer=0.
REQ-040 After reset is released, the block SHALL accept inValid on the first rising edge.
REQ-041 Assertion of reset mid-inference SHALL discard the inference with no resultValid.

Verification
REQ-042 Nominal: inValid; l0OutValid after 785 cycles; l1OutValid after 17 cycles; scores {1,5,-3,9,2,0,0,0,0,9} -> result=3, resultScore=9, one resultValid pulse, latency 815.
REQ-043 Ties and negatives: all scores = -4 -> result=0, resultScore=-4; scores 0x8000 except index 9 = 0x8001 -> result=9.
REQ-044 Timeout: l0OutValid never asserts -> timeoutErr=1 at cycle timeoutCycles, l0Valid=0, inReady=1, no resultValid; the next inValid clears timeoutErr.
REQ-045 Abort: abort in L1_RUN coinciding with l1OutValid -> IDLE, no resultValid, l1In retains the layer 0 capture.
REQ-046 Reset: reset low during ARGMAX -> all outputs at REQ-039 values immediately; a fresh inference afterwards completes correctly.
REQ-047 Exclusivity: across 100 randomized-latency inferences, l0Valid&l1Valid is never 1, and exactly one resultValid occurs per accept without timeout or abort.
